// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the serial Hamming decoder.
package hamming_pkg;

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    CHECK = 2'd1,
    OUT   = 2'd2
  } state_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Smallest parity count p with 2^p >= data_w + p + 1.
  function automatic int unsigned required_par_w(input int unsigned data_w);
    int unsigned p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  // 1-based codeword position holding data bit idx (non-power-of-two slots, ascending).
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned pos;
    int unsigned seen;
    pos  = 0;
    seen = 0;
    for (int unsigned p = 1; p < 1024; p++) begin
      if (!is_pow2(p) && pos == 0) begin
        if (seen == idx) pos = p;
        seen++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational syndrome, overall parity, correction mask and data extraction.
// Build option: define SECDED_EN to interpret the last code bit as overall even parity.
module hamming_syndrome_calc
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int CODE_W = 7
) (
  input  logic [CODE_W-1:0] code,
  output logic [PAR_W-1:0]  syndrome,
  output logic [DATA_W-1:0] data,
  output logic              err_corrected,
  output logic              err_uncorrectable
);

  localparam int HAM_W = DATA_W + PAR_W;
  localparam logic [PAR_W:0] HAM_LIM = (PAR_W + 1)'(HAM_W);

  logic              in_range;
  logic              flip;
  logic [HAM_W-1:0]  mask;
  logic [HAM_W-1:0]  fixed;

  always_comb begin
    syndrome = '0;
    for (int k = 0; k < HAM_W; k++) begin
      for (int j = 0; j < PAR_W; j++) begin
        if ((((k + 1) >> j) & 1) != 0) syndrome[j] = syndrome[j] ^ code[k];
      end
    end
  end

  assign in_range = (syndrome != '0) && ({1'b0, syndrome} <= HAM_LIM);

  always_comb begin
    flip              = 1'b0;
    err_corrected     = 1'b0;
    err_uncorrectable = 1'b0;
`ifdef SECDED_EN
    // Odd overall parity means an odd number of flips; syndrome 0 blames the parity bit itself.
    if (^code) begin
      if (syndrome == '0) begin
        err_corrected = 1'b1;
      end else if (in_range) begin
        flip          = 1'b1;
        err_corrected = 1'b1;
      end else begin
        err_uncorrectable = 1'b1;
      end
    end else if (syndrome != '0) begin
      err_uncorrectable = 1'b1;
    end
`else
    if (syndrome != '0) begin
      if (in_range) begin
        flip          = 1'b1;
        err_corrected = 1'b1;
      end else begin
        err_uncorrectable = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    mask = '0;
    for (int k = 0; k < HAM_W; k++) begin
      mask[k] = flip && ({1'b0, syndrome} == (PAR_W + 1)'(k + 1));
    end
  end

  assign fixed = code[HAM_W-1:0] ^ mask;

  for (genvar i = 0; i < DATA_W; i++) begin : g_extract
    localparam int POS = int'(data_pos(i));
    assign data[i] = fixed[POS-1];
  end

endmodule

// File: rtl/hamming_serial_decoder.sv
// Serial LSB-first Hamming receiver: shift, check, present on a valid/ready output.
// Build option: define SECDED_EN to receive and use one extra overall-parity bit.
module hamming_serial_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              strobe_in,
  output logic              in_ready,
  input  logic              frame_abort,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PAR_W-1:0]  syndrome,
  output logic              err_corrected,
  output logic              err_uncorrectable,
  output logic              overrun,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  localparam int HAM_W = DATA_W + PAR_W;
`ifdef SECDED_EN
  localparam int CODE_W = HAM_W + 1;
`else
  localparam int CODE_W = HAM_W;
`endif
  localparam int CNT_BITS = $clog2(CODE_W + 1);

  if (PAR_W < int'(required_par_w(DATA_W))) begin : g_par_check
    $error("PAR_W too small for DATA_W");
  end

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   bit_cnt_q;
  logic [CODE_W-1:0]     code_q;
  logic                  take_bit;
  logic                  last_bit;
  logic [PAR_W-1:0]      calc_syn;
  logic [DATA_W-1:0]     calc_data;
  logic                  calc_corr;
  logic                  calc_uncorr;

  hamming_syndrome_calc #(
    .DATA_W(DATA_W),
    .PAR_W (PAR_W),
    .CODE_W(CODE_W)
  ) u_calc (
    .code             (code_q),
    .syndrome         (calc_syn),
    .data             (calc_data),
    .err_corrected    (calc_corr),
    .err_uncorrectable(calc_uncorr)
  );

  // Abort outranks a simultaneous strobe.
  assign take_bit = (state_q == SHIFT) && strobe_in && !frame_abort;
  assign last_bit = take_bit && (bit_cnt_q == CNT_BITS'(CODE_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= SHIFT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHIFT:   if (last_bit) state_d = CHECK;
      CHECK:   state_d = OUT;
      OUT:     if (out_ready) state_d = SHIFT;
      default: state_d = SHIFT;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == SHIFT);
    out_valid = (state_q == OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q         <= '0;
      code_q            <= '0;
      out_data          <= '0;
      syndrome          <= '0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
      overrun           <= 1'b0;
      corr_count        <= '0;
      uncorr_count      <= '0;
    end else begin
      if (strobe_in && state_q != SHIFT) overrun <= 1'b1;
      case (state_q)
        SHIFT: begin
          if (frame_abort) begin
            bit_cnt_q <= '0;
            code_q    <= '0;
          end else if (strobe_in) begin
            for (int k = 0; k < CODE_W; k++) begin
              if (bit_cnt_q == CNT_BITS'(k)) code_q[k] <= bit_in;
            end
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        CHECK: begin
          out_data          <= calc_data;
          syndrome          <= calc_syn;
          err_corrected     <= calc_corr;
          err_uncorrectable <= calc_uncorr;
          if (calc_corr && corr_count != '1)     corr_count   <= corr_count + 1'b1;
          if (calc_uncorr && uncorr_count != '1) uncorr_count <= uncorr_count + 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            bit_cnt_q <= '0;
            code_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Scoreboard bench for hamming_serial_decoder; honours SECDED_EN for the codeword length.
module tb_hamming_serial_decoder;

  localparam int DATA_W = 4;
  localparam int PAR_W  = 3;
  localparam int CNT_W  = 8;
  localparam int HAM_W  = DATA_W + PAR_W;
`ifdef SECDED_EN
  localparam int CODE_W = HAM_W + 1;
`else
  localparam int CODE_W = HAM_W;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PAR_W-1:0]  syn;
    logic              c;
    logic              u;
    logic [CNT_W-1:0]  cc;
    logic [CNT_W-1:0]  uc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              bit_in;
  logic              strobe_in;
  logic              in_ready;
  logic              frame_abort;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [PAR_W-1:0]  syndrome;
  logic              err_corrected;
  logic              err_uncorrectable;
  logic              overrun;
  logic [CNT_W-1:0]  corr_count;
  logic [CNT_W-1:0]  uncorr_count;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] model_cc = '0;
  logic [CNT_W-1:0] model_uc = '0;
  logic             hold_ready = 1'b0;

  hamming_serial_decoder #(
    .DATA_W(DATA_W),
    .PAR_W (PAR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bit_in           (bit_in),
    .strobe_in        (strobe_in),
    .in_ready         (in_ready),
    .frame_abort      (frame_abort),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .syndrome         (syndrome),
    .err_corrected    (err_corrected),
    .err_uncorrectable(err_uncorrectable),
    .overrun          (overrun),
    .corr_count       (corr_count),
    .uncorr_count     (uncorr_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    int s;
    int di;
    cw = '0;
    s  = 0;
    di = 0;
    for (int p = 1; p <= HAM_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[di];
        di++;
      end
    end
    for (int p = 1; p <= HAM_W; p++) if (cw[p-1]) s ^= p;
    for (int j = 0; j < PAR_W; j++) cw[(1 << j) - 1] = s[j];
`ifdef SECDED_EN
    cw[CODE_W-1] = ^cw[HAM_W-1:0];
`endif
    return cw;
  endfunction

  task automatic model_decode(input logic [CODE_W-1:0] cw, output logic [DATA_W-1:0] d,
                              output logic [PAR_W-1:0] syn, output logic c, output logic u);
    logic [HAM_W-1:0] h;
    int s;
    int di;
    logic ov;
    logic flip;
    h = cw[HAM_W-1:0];
    s = 0;
    for (int p = 1; p <= HAM_W; p++) if (h[p-1]) s ^= p;
`ifdef SECDED_EN
    ov = ^cw;
`else
    ov = 1'b1;
`endif
    c = 1'b0;
    u = 1'b0;
    flip = 1'b0;
    if (s == 0) begin
      c = ov && (CODE_W != HAM_W);
    end else if (!ov) begin
      u = 1'b1;
    end else if (s <= HAM_W) begin
      flip = 1'b1;
      c = 1'b1;
    end else begin
      u = 1'b1;
    end
    if (flip) h[s-1] = ~h[s-1];
    di = 0;
    d  = '0;
    for (int p = 1; p <= HAM_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = h[p-1];
        di++;
      end
    end
    syn = PAR_W'(s);
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic [PAR_W-1:0] syn,
                          input logic c, input logic u);
    exp_t e;
    if (c && model_cc != CNT_MAX) model_cc = model_cc + 1'b1;
    if (u && model_uc != CNT_MAX) model_uc = model_uc + 1'b1;
    e.data = d;
    e.syn  = syn;
    e.c    = c;
    e.u    = u;
    e.cc   = model_cc;
    e.uc   = model_uc;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input logic abort);
    int w;
    repeat ($urandom_range(0, 1)) tick();
    w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
    bit_in      = b;
    strobe_in   = 1'b1;
    frame_abort = abort;
    tick();
    strobe_in   = 1'b0;
    frame_abort = 1'b0;
  endtask

  task automatic send_word(input logic [CODE_W-1:0] cw);
    for (int k = 0; k < CODE_W; k++) send_bit(cw[k], 1'b0);
  endtask

  task automatic wait_valid();
    int w;
    w = 0;
    while (!out_valid && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      tick();
      w++;
    end
    if (w >= 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic r;
    logic held;
    logic [DATA_W+PAR_W+1:0] snap;
    exp_t e;
    out_ready = 1'b0;
    held = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_stable", 32'({out_data, syndrome, err_corrected, err_uncorrectable}),
                32'(snap));
        end
        r = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        out_ready = r;
        held = 1'b0;
        if (out_valid) begin
          if (r) begin
            if (exp_q.size() == 0) begin
              check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("out_data", 32'(out_data), 32'(e.data));
              check("syndrome", 32'(syndrome), 32'(e.syn));
              check("err_corrected", 32'(err_corrected), 32'(e.c));
              check("err_uncorrectable", 32'(err_uncorrectable), 32'(e.u));
              check("corr_count", 32'(corr_count), 32'(e.cc));
              check("uncorr_count", 32'(uncorr_count), 32'(e.uc));
            end
          end else begin
            held = 1'b1;
            snap = {out_data, syndrome, err_corrected, err_uncorrectable};
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    check("global_timeout", 32'd1, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [CODE_W-1:0] cw;
    logic [DATA_W-1:0] d;
    logic [PAR_W-1:0]  syn;
    logic              c;
    logic              u;
    int                i0;
    int                i1;

    rst = 1'b1;
    bit_in = 1'b0;
    strobe_in = 1'b0;
    frame_abort = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_syndrome", 32'(syndrome), 32'd0);
    check("rst_flags", 32'({err_corrected, err_uncorrectable, overrun}), 32'd0);
    check("rst_counts", 32'({corr_count, uncorr_count}), 32'd0);

    // Clean word and output latency.
    push_exp(4'hB, 3'd0, 1'b0, 1'b0);
    send_word(CODE_W'('h55));
    check("latency_check_cycle", 32'(out_valid), 32'd0);
    tick();
    check("latency_out_cycle", 32'(out_valid), 32'd1);
    drain();

    // Single error at position 4.
    push_exp(4'hB, 3'd4, 1'b1, 1'b0);
    send_word(CODE_W'('h5D));
    drain();

    // Double error in bits 0 and 1.
`ifdef SECDED_EN
    push_exp(4'hB, 3'd3, 1'b0, 1'b1);
`else
    push_exp(4'hA, 3'd3, 1'b1, 1'b0);
`endif
    send_word(CODE_W'('h56));
    drain();

    // Abort after three bits, the abort cycle also carrying a strobe.
    for (int k = 0; k < 3; k++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_bit(1'b1, 1'b1);
    push_exp(4'hB, 3'd0, 1'b0, 1'b0);
    send_word(CODE_W'('h55));
    drain();
    check("abort_no_overrun", 32'(overrun), 32'd0);

    // Backpressure with strobes while the output is held.
    hold_ready = 1'b1;
    push_exp(4'hB, 3'd0, 1'b0, 1'b0);
    send_word(CODE_W'('h55));
    wait_valid();
    check("overrun_before", 32'(overrun), 32'd0);
    for (int k = 0; k < 5; k++) begin
      bit_in = 1'($urandom_range(0, 1));
      strobe_in = 1'b1;
      tick();
    end
    strobe_in = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    check("in_ready_held", 32'(in_ready), 32'd0);
    hold_ready = 1'b0;
    push_exp(4'hB, 3'd4, 1'b1, 1'b0);
    send_word(CODE_W'('h5D));
    drain();

    // Randomized words, enough corrections to saturate the counter.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < $urandom_range(1, CODE_W - 1); k++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        send_bit(1'($urandom_range(0, 1)), 1'b1);
      end
      d  = DATA_W'($urandom);
      cw = encode(d);
      i0 = $urandom_range(0, 7);
      if (i0 >= 2) begin
        i1 = $urandom_range(0, CODE_W - 1);
        cw[i1] = ~cw[i1];
        if (i0 == 7) begin
          i0 = (i1 + $urandom_range(1, CODE_W - 1)) % CODE_W;
          cw[i0] = ~cw[i0];
        end
      end
      model_decode(cw, d, syn, c, u);
      push_exp(d, syn, c, u);
      send_word(cw);
    end
    drain();
    check("corr_saturated", 32'(corr_count), 32'(CNT_MAX));
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while a word is being presented.
    hold_ready = 1'b1;
    push_exp(4'hB, 3'd0, 1'b0, 1'b0);
    send_word(CODE_W'('h55));
    wait_valid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_cc = '0;
    model_uc = '0;
    check("rstout_out_valid", 32'(out_valid), 32'd0);
    check("rstout_in_ready", 32'(in_ready), 32'd1);
    check("rstout_counts", 32'({corr_count, uncorr_count}), 32'd0);
    check("rstout_overrun", 32'(overrun), 32'd0);
    check("rstout_data", 32'({out_data, syndrome, err_corrected, err_uncorrectable}), 32'd0);
    hold_ready = 1'b0;
    push_exp(4'hB, 3'd4, 1'b1, 1'b0);
    send_word(CODE_W'('h5D));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
